// File: rtl/uart_tx_plnk_buf.sv
// 8N1 UART transmitter fed by a small byte FIFO; line falls two cycles after a write into an idle block.
// Backpressure: o_Tx_Ready (registered FIFO not-full); writes while not ready are dropped and flagged on o_Overflow.

module uart_tx_plnk_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  output logic          wr_rdy,
  input  logic          rd_vld,
  output logic [W-1:0]  rd_dat,
  output logic [AW:0]   count,
  output logic          ovf_vld
);

  localparam logic [AW:0]   FULL    = (AW+1)'(1 << AW);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;
  logic [AW:0]   count_nxt;

  always_comb begin
    wr_en     = wr_vld & wr_rdy;
    rd_en     = rd_vld & (count != '0);
    count_nxt = count;
    if (wr_en && !rd_en)
      count_nxt = count + CNT_ONE;
    else if (!wr_en && rd_en)
      count_nxt = count - CNT_ONE;
  end

  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge i_Clock) begin
    if (wr_en)
      mem[wr_ptr] <= wr_dat;
  end

  // Ready is registered from count_nxt, so a pop frees space only from the following edge.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wr_rdy  <= 1'b1;
      ovf_vld <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en)
        rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_nxt;
      wr_rdy  <= (count_nxt < FULL);
      ovf_vld <= wr_vld & ~wr_rdy;
    end
  end

endmodule

module uart_tx_plnk_buf #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 2
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Tx_DV,
  input  logic [7:0]         i_Tx_Byte,
  output logic               o_Tx_Ready,
  output logic               o_Tx_Serial,
  output logic               o_Tx_Active,
  output logic               o_Tx_Done,
  output logic               o_Overflow,
  output logic [FIFO_AW:0]   o_Fifo_Count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [15:0] clk_count;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_dat;
  logic        pop_vld;
  logic [7:0]  head_dat;
  logic        bit_end;

  assign pop_vld = (state == IDLE) && (o_Fifo_Count != '0);
  assign bit_end = (clk_count == LAST);

  uart_tx_plnk_fifo #(
    .W  (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .wr_vld  (i_Tx_DV),
    .wr_dat  (i_Tx_Byte),
    .wr_rdy  (o_Tx_Ready),
    .rd_vld  (pop_vld),
    .rd_dat  (head_dat),
    .count   (o_Fifo_Count),
    .ovf_vld (o_Overflow)
  );

  // Line and status are registered, so they lag the state register by one edge.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= IDLE;
      clk_count   <= '0;
      bit_idx     <= '0;
      shift_dat   <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      case (state)
        IDLE: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          clk_count   <= '0;
          bit_idx     <= '0;
          if (pop_vld) begin
            shift_dat <= head_dat;
            state     <= START;
          end
        end
        START: begin
          o_Tx_Serial <= 1'b0;
          o_Tx_Active <= 1'b1;
          if (bit_end) begin
            clk_count <= '0;
            bit_idx   <= '0;
            state     <= DATA;
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end
        DATA: begin
          o_Tx_Serial <= shift_dat[bit_idx];
          o_Tx_Active <= 1'b1;
          if (bit_end) begin
            clk_count <= '0;
            if (bit_idx == 3'd7)
              state <= STOP;
            else
              bit_idx <= bit_idx + 3'd1;
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end
        STOP: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b1;
          if (bit_end) begin
            clk_count <= '0;
            state     <= CLEANUP;
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end
        CLEANUP: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          o_Tx_Done   <= 1'b1;
          clk_count   <= '0;
          state       <= IDLE;
        end
        default: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          clk_count   <= '0;
          bit_idx     <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_plnk_buf.sv
// Directed bench for uart_tx_plnk_buf: fast-baud instance for frame/FIFO behaviour, default-baud instance for bit timing.
module tb_uart_tx_plnk_buf;

  localparam int C = 8;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b1;
  logic       a_dv = 1'b0;
  logic [7:0] a_byte = 8'h00;
  logic       a_ready, a_serial, a_active, a_done, a_ovf;
  logic [2:0] a_count;
  logic       b_dv = 1'b0;
  logic [7:0] b_byte = 8'h00;
  logic       b_ready, b_serial, b_active, b_done, b_ovf;
  logic [2:0] b_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int         rx_fall[$];
  bit         rx_ok[$];
  int         mon_f;
  logic [7:0] mon_d;
  logic       mon_st, mon_sp;

  uart_tx_plnk_buf #(.CLKS_PER_BIT(C), .FIFO_AW(2)) dut_a (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Tx_DV(a_dv), .i_Tx_Byte(a_byte),
    .o_Tx_Ready(a_ready), .o_Tx_Serial(a_serial), .o_Tx_Active(a_active),
    .o_Tx_Done(a_done), .o_Overflow(a_ovf), .o_Fifo_Count(a_count));

  uart_tx_plnk_buf dut_b (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Tx_DV(b_dv), .i_Tx_Byte(b_byte),
    .o_Tx_Ready(b_ready), .o_Tx_Serial(b_serial), .o_Tx_Active(b_active),
    .o_Tx_Done(b_done), .o_Overflow(b_ovf), .o_Fifo_Count(b_count));

  always #5 i_Clock = ~i_Clock;
  always @(posedge i_Clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic write_a(input logic [7:0] d);
    a_byte = d;
    a_dv   = 1'b1;
    tick();
    a_dv   = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) tick();
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_fall.delete();
    rx_ok.delete();
  endtask

  // Receiver model on dut_a's line: mid-bit sampling, same as a loopback UART RX.
  always begin : rx_model
    tick();
    if (a_serial === 1'b0) begin
      mon_f = cyc;
      repeat (C/2) tick();
      mon_st = a_serial;
      for (int j = 0; j < 8; j++) begin
        repeat (C) tick();
        mon_d[j] = a_serial;
      end
      repeat (C) tick();
      mon_sp = a_serial;
      rx_q.push_back(mon_d);
      rx_fall.push_back(mon_f);
      rx_ok.push_back(mon_st === 1'b0 && mon_sp === 1'b1);
    end
  end

  task automatic test_reset();
    i_Reset = 1'b1;
    repeat (3) tick();
    checks++; if ({a_serial, a_ready, a_active, a_done, a_ovf} !== 5'b11000) begin errors++; $display("FAIL reset_flags got %b want 11000", {a_serial, a_ready, a_active, a_done, a_ovf}); end
    checks++; if (a_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", a_count); end
    checks++; if ({b_serial, b_ready, b_active} !== 3'b110) begin errors++; $display("FAIL reset_b got %b want 110", {b_serial, b_ready, b_active}); end
    i_Reset = 1'b0;
    repeat (3) tick();
    checks++; if ({a_serial, a_ready, a_active, a_done, a_ovf, a_count} !== 8'b11000_000) begin errors++; $display("FAIL post_reset_idle got %b want 11000000", {a_serial, a_ready, a_active, a_done, a_ovf, a_count}); end
  endtask

  task automatic test_single_frame();
    logic [7:0] pat;
    logic e_line;
    pat = 8'hA5;
    write_a(pat);
    checks++; if (a_count !== 3'd1) begin errors++; $display("FAIL single_count0 got %0d want 1", a_count); end
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (k < 2) e_line = 1'b1;
      else if (k < 10) e_line = 1'b0;
      else if (k < 74) e_line = pat[(k-10)/8];
      else e_line = 1'b1;
      checks++; if (a_serial !== e_line) begin errors++; $display("FAIL single_line k=%0d got %b want %b", k, a_serial, e_line); end
      checks++; if (a_done !== (k == 82)) begin errors++; $display("FAIL single_done k=%0d got %b want %b", k, a_done, (k == 82)); end
      checks++; if (a_active !== (k >= 2 && k < 82)) begin errors++; $display("FAIL single_active k=%0d got %b want %b", k, a_active, (k >= 2 && k < 82)); end
      if (k == 1) begin
        checks++; if (a_count !== 3'd0) begin errors++; $display("FAIL single_count1 got %0d want 0", a_count); end
      end
    end
    checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'hA5) begin errors++; $display("FAIL single_loopback got n=%0d b=%h want n=1 b=a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
    clear_rx();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5];
    logic [2:0] e_cnt [5];
    logic       e_rdy [5];
    int w0;
    bytes = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81};
    e_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    e_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    clear_rx();
    w0 = 0;
    for (int i = 0; i < 5; i++) begin
      a_byte = bytes[i];
      a_dv = 1'b1;
      tick();
      if (i == 0) w0 = cyc;
      checks++; if (a_count !== e_cnt[i] || a_ready !== e_rdy[i]) begin errors++; $display("FAIL b2b_fill i=%0d got cnt=%0d rdy=%b want cnt=%0d rdy=%b", i, a_count, a_ready, e_cnt[i], e_rdy[i]); end
    end
    a_byte = 8'hEE;
    tick();
    a_dv = 1'b0;
    checks++; if (a_ovf !== 1'b1 || a_count !== 3'd4 || a_ready !== 1'b0) begin errors++; $display("FAIL overflow got ovf=%b cnt=%0d rdy=%b want 1 4 0", a_ovf, a_count, a_ready); end
    tick();
    checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL overflow_pulse got %b want 0", a_ovf); end
    wait_frames(5, 600);
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL b2b_frames got %0d want 5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== bytes[i] || !rx_ok[i]) begin errors++; $display("FAIL b2b_byte i=%0d got %h ok=%b want %h ok=1", i, rx_q[i], rx_ok[i], bytes[i]); end
      if (i > 0) begin
        checks++; if (rx_fall[i] - rx_fall[i-1] != 10*C + 2) begin errors++; $display("FAIL b2b_gap i=%0d got %0d want %0d", i, rx_fall[i] - rx_fall[i-1], 10*C + 2); end
      end
    end
    if (rx_fall.size() > 0) begin
      checks++; if (rx_fall[0] != w0 + 2) begin errors++; $display("FAIL b2b_first_fall got %0d want %0d", rx_fall[0], w0 + 2); end
    end
    repeat (100) tick();
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL no_ee_sent got %0d frames want 5", rx_q.size()); end
    clear_rx();
  endtask

  task automatic test_full_pop_collision();
    logic [7:0] bytes [5];
    int n;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    clear_rx();
    for (int i = 0; i < 5; i++) begin
      a_byte = bytes[i];
      a_dv = 1'b1;
      tick();
    end
    a_dv = 1'b0;
    n = 0;
    while (a_done !== 1'b1 && n < 200) begin tick(); n++; end
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL collide_wait_done got %b want 1", a_done); end
    checks++; if (a_count !== 3'd4 || a_ready !== 1'b0) begin errors++; $display("FAIL collide_pre got cnt=%0d rdy=%b want 4 0", a_count, a_ready); end
    a_byte = 8'h99;
    a_dv = 1'b1;
    tick();
    a_dv = 1'b0;
    checks++; if (a_ovf !== 1'b1 || a_ready !== 1'b1 || a_count !== 3'd3) begin errors++; $display("FAIL collide_post got ovf=%b rdy=%b cnt=%0d want 1 1 3", a_ovf, a_ready, a_count); end
    wait_frames(5, 600);
    repeat (100) tick();
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL collide_frames got %0d want 5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== bytes[i] || !rx_ok[i]) begin errors++; $display("FAIL collide_byte i=%0d got %h ok=%b want %h ok=1", i, rx_q[i], rx_ok[i], bytes[i]); end
    end
    clear_rx();
  endtask

  task automatic test_reset_mid_frame();
    int lows, dones;
    write_a(8'h0F);
    repeat (45) tick();
    checks++; if (a_serial !== 1'b0 || a_active !== 1'b1) begin errors++; $display("FAIL midframe_pre got line=%b act=%b want 0 1", a_serial, a_active); end
    #3 i_Reset = 1'b1;
    #1;
    checks++; if (a_serial !== 1'b1 || a_active !== 1'b0 || a_count !== 3'd0 || a_ready !== 1'b1) begin errors++; $display("FAIL midframe_reset got line=%b act=%b cnt=%0d rdy=%b want 1 0 0 1", a_serial, a_active, a_count, a_ready); end
    repeat (2) tick();
    i_Reset = 1'b0;
    lows = 0;
    dones = 0;
    for (int k = 0; k < 90; k++) begin
      tick();
      if (a_serial !== 1'b1) lows++;
      if (a_done !== 1'b0) dones++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL after_reset_line got %0d low cycles want 0", lows); end
    checks++; if (dones != 0) begin errors++; $display("FAIL after_reset_done got %0d pulses want 0", dones); end
    clear_rx();
    write_a(8'h42);
    wait_frames(1, 200);
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h42 || !rx_ok[0]) begin errors++; $display("FAIL after_reset_tx got n=%0d b=%h want n=1 b=42", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
    repeat (10) tick();
    clear_rx();
  endtask

  task automatic test_default_baud();
    int trans [16];
    int ntrans, act_cnt, act_fall, maxc, dcount, w;
    logic prev, prev_act;
    b_byte = 8'h55;
    b_dv = 1'b1;
    tick();
    b_dv = 1'b0;
    w = cyc;
    ntrans = 0; act_cnt = 0; act_fall = -1; maxc = 0; dcount = 0;
    prev = 1'b1; prev_act = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      tick();
      if (b_serial !== prev) begin
        if (ntrans < 16) trans[ntrans] = cyc;
        ntrans++;
        prev = b_serial;
      end
      if (b_active === 1'b1) act_cnt++;
      if (prev_act === 1'b1 && b_active === 1'b0) act_fall = cyc;
      prev_act = b_active;
      if (int'(dut_b.clk_count) > maxc) maxc = int'(dut_b.clk_count);
      if (b_done === 1'b1) dcount++;
      if (act_fall >= 0 && cyc > act_fall + 4) break;
    end
    checks++; if (ntrans != 10) begin errors++; $display("FAIL baud_transitions got %0d want 10", ntrans); end
    if (ntrans == 10) begin
      checks++; if (trans[0] != w + 2) begin errors++; $display("FAIL baud_first_fall got %0d want %0d", trans[0], w + 2); end
      for (int i = 1; i < 10; i++) begin
        checks++; if (trans[i] - trans[i-1] != 434) begin errors++; $display("FAIL baud_bit i=%0d got %0d want 434", i, trans[i] - trans[i-1]); end
      end
      checks++; if (act_fall - trans[9] != 434) begin errors++; $display("FAIL baud_stop got %0d want 434", act_fall - trans[9]); end
    end
    checks++; if (act_cnt != 4340) begin errors++; $display("FAIL baud_frame got %0d want 4340", act_cnt); end
    checks++; if (maxc > 433 || maxc < 433) begin errors++; $display("FAIL baud_counter_max got %0d want 433", maxc); end
    checks++; if (dcount != 1) begin errors++; $display("FAIL baud_done got %0d want 1", dcount); end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_full_pop_collision();
    test_reset_mid_frame();
    test_default_baud();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_plnk_buf.md
Name: uart_tx_plnk_buf

Overview:
8N1 UART transmitter (1 start, 8 data LSB-first, 1 stop, no parity) with a small input FIFO.
- Accepts bytes from the PLANK feedback logic via a valid/ready strobe and serialises them onto the TX pin.
- Line-compatible with uart_rx_PLNK at the same CLKS_PER_BIT.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit; i_Clock freq / baud (50 MHz / 115200). Legal range 4..65535.
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (default 4).

Ports:
i_Clock  in  1  system clock; all logic on rising edge
i_Reset  in  1  asynchronous, active-high reset
i_Tx_DV  in  1  write strobe; byte accepted when i_Tx_DV=1 and o_Tx_Ready=1 on the same edge
i_Tx_Byte  in  8  byte to transmit, sampled with i_Tx_DV
o_Tx_Ready  out  1  FIFO not full (registered)
o_Tx_Serial  out  1  serial line, idle high, registered
o_Tx_Active  out  1  high from first start-bit cycle through last stop-bit cycle
o_Tx_Done  out  1  one-cycle pulse after each frame's stop bit completes
o_Overflow  out  1  one-cycle pulse when i_Tx_DV=1 while o_Tx_Ready=0 (byte dropped)
o_Fifo_Count  out  FIFO_AW+1  bytes held in FIFO, excluding the byte being shifted

Behaviour:
- Reset (async assert, sync release):
  - o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0, o_Fifo_Count=0.
  - FIFO emptied, state=IDLE, counters=0.
  - Reset mid-frame aborts the frame; the line goes high immediately, with no partial-frame completion.
- FIFO: circular buffer, wr/rd pointers FIFO_AW bits wide, wrapping modulo depth. Count is a separate register.
  - Write when count<depth; read (pop) only from IDLE.
  - Simultaneous write+pop: count unchanged and both succeed.
  - Write when full: ignored, o_Overflow pulses, FIFO contents untouched.
  - o_Tx_Ready is the registered value (count_next < depth), so a pop does not free space for a write on the same edge.
- State machine (3-bit): IDLE, START, DATA, STOP, CLEANUP; undefined encodings go to IDLE.
  - IDLE: line=1. If count>0, pop head into shift register and go to START. Otherwise stay.
  - START: line=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: line=shift[bit index] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles, then CLEANUP.
  - CLEANUP: one cycle, line=1, o_Tx_Done=1, then IDLE.
- Timing:
  - First byte into an idle, empty block: write at edge N, pop at N+1, line falls at N+2.
  - Frame occupies 10*CLKS_PER_BIT line cycles.
  - Back-to-back frames from a non-empty FIFO are separated by exactly 2 high cycles (CLEANUP + IDLE).
- Clock counter: 16 bits, counts 0..CLKS_PER_BIT-1 per bit, reset to 0 at every bit boundary.
- o_Tx_Active=1 in START/DATA/STOP, 0 in IDLE/CLEANUP.
- The popped byte is held in a dedicated shift register, so FIFO writes during a frame never corrupt the byte in flight.

Test Plan:
1. CLKS_PER_BIT=8, write 0xA5 once.
   - Line goes low 2 cycles after the write and stays low 8 cycles.
   - Data bits 1,0,1,0,0,1,0,1 follow, 8 cycles each, then stop high 8 cycles.
   - o_Tx_Done pulses once at cycle 82 after the write.
   - Loopback into uart_rx_PLNK (CLKS_PER_BIT=8) yields o_Rx_Byte=0xA5.
2. Write 0x00,0xFF,0x55,0x3C,0x81 on consecutive cycles, FIFO_AW=2.
   - The first four bytes are accepted (one is popped after the second cycle).
   - The fifth is also accepted since count≤4; the Ready/count trace must be checked against the FIFO rules.
   - All 5 are received in order via loopback, each frame separated by exactly 2 high cycles.
3. Fill the FIFO to 4 while a frame is in flight, then pulse i_Tx_DV with 0xEE.
   - o_Tx_Ready=0, o_Overflow pulses once, o_Fifo_Count stays 4.
   - 0xEE is never transmitted.
4. Write while count=depth and a pop occurs on the same edge.
   - The write is rejected (Ready was 0) and o_Overflow pulses.
   - On the next cycle o_Tx_Ready=1 and count=3.
5. Assert i_Reset mid-DATA of 0x0F, between clock edges.
   - o_Tx_Serial=1 and o_Tx_Active=0 immediately, count=0.
   - After release, the line stays high, no o_Tx_Done pulse, and a new write of 0x42 transmits correctly.
6. Default CLKS_PER_BIT=434.
   - Each bit is exactly 434 cycles and the frame is 4340 cycles.
   - Clock counter never exceeds 433.
